// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared types and defaults for the uart_tx arbiter slice.
//               FSM state encoding, uart_tx word-format defaults, and an
//               index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARB       = 3'd1,
      ST_ISSUE     = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4,
      ST_GAP       = 3'd5,
      ST_RELEASE   = 3'd6
   } arb_state_t;

   // S.BUS 8E2 framing: 8 data + parity + 2 stop bits
   localparam int C_DEF_PAYLOAD_BITS = 11;
   localparam int C_DEF_NUM_REQ      = 2;
   localparam int C_DEF_GAP_CYCLES   = 0;
   localparam int C_DEF_LOCK_TIMEOUT = 65535;

   // Bits needed to hold values 0..n-1, never less than one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first valid
//               requester searching upward from (ptr+1) mod N with wrap, as a
//               one-hot vector, plus an any-valid flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N = 2,
   localparam int IW = idx_width(N)
)(
   input  logic [N-1:0]  i_valid,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_onehot,
   output logic          o_any
);

   logic [IW-1:0] w_idx;

   // Scan candidates in priority order; the first valid one wins
   always_comb begin
      o_onehot = '0;
      o_any    = 1'b0;
      w_idx    = '0;
      for (int i = 1; i <= N; i++) begin
         w_idx = IW'((int'(i_ptr) + i) % N);
         if (!o_any && i_valid[w_idx]) begin
            o_onehot[w_idx] = 1'b1;
            o_any           = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one uart_tx between NUM_REQ
//               packet requesters. Grant is locked per packet, with an
//               optional idle gap after each packet.
//               Build option: define ARB_TIMEOUT_EN to add a stall timeout
//               that force-releases a stuck lock and raises lock_err.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = C_DEF_NUM_REQ,
   parameter int PAYLOAD_BITS = C_DEF_PAYLOAD_BITS,
   parameter int GAP_CYCLES   = C_DEF_GAP_CYCLES
`ifdef ARB_TIMEOUT_EN
   , parameter int LOCK_TIMEOUT = C_DEF_LOCK_TIMEOUT
`endif
)(
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
   input  logic [NUM_REQ-1:0]              req_last,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              grant,
   output logic                            uart_tx_en,
   output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
   input  logic                            uart_tx_busy,
   output logic                            pkt_active
`ifdef ARB_TIMEOUT_EN
   , output logic                          lock_err
`endif
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int GW = idx_width(GAP_CYCLES + 1);

   arb_state_t              r_state;
   arb_state_t              w_state_nxt;
   logic [IW-1:0]           r_ptr;
   logic [IW-1:0]           w_win_idx;
   logic [NUM_REQ-1:0]      w_win_oh;
   logic                    w_any;
   logic [NUM_REQ-1:0]      r_grant;
   logic                    r_pkt_active;
   logic                    r_en;
   logic [PAYLOAD_BITS-1:0] r_data;
   logic                    r_last;
   logic [GW-1:0]           r_gap_cnt;
   logic                    w_gap_done;
   logic                    w_g_valid;
   logic                    w_g_last;
   logic [PAYLOAD_BITS-1:0] w_g_data;
   logic                    w_accept;
   logic                    w_to_hit;

   rr_pick #(
      .N (NUM_REQ)
   ) u_rr_pick (
      .i_valid  (req_valid),
      .i_ptr    (r_ptr),
      .o_onehot (w_win_oh),
      .o_any    (w_any)
   );

   // Encode the one-hot winner so the pointer can be updated
   always_comb begin
      w_win_idx = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (w_win_oh[r]) w_win_idx = IW'(r);
      end
   end

   // Route the granted requester's word, valid and last flag
   always_comb begin
      w_g_valid = 1'b0;
      w_g_last  = 1'b0;
      w_g_data  = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (r_grant[r]) begin
            w_g_valid = req_valid[r];
            w_g_last  = req_last[r];
            w_g_data  = req_data[r*PAYLOAD_BITS +: PAYLOAD_BITS];
         end
      end
   end

   assign w_gap_done = (int'(r_gap_cnt) >= GAP_CYCLES - 1);

   // Next-state logic; a word is taken only when the line is free
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (|req_valid) w_state_nxt = ST_ARB;
         end
         ST_ARB: begin
            // requests may have vanished since IDLE; fall back if so
            w_state_nxt = w_any ? ST_ISSUE : ST_IDLE;
         end
         ST_ISSUE: begin
            if (w_g_valid && !uart_tx_busy) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_WAIT_BUSY;
            end else if (w_to_hit) begin
               w_state_nxt = ST_RELEASE;
            end
         end
         ST_WAIT_BUSY: begin
            if (uart_tx_busy) w_state_nxt = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!uart_tx_busy) begin
               if (!r_last)              w_state_nxt = ST_ISSUE;
               else if (GAP_CYCLES == 0) w_state_nxt = ST_RELEASE;
               else                      w_state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (w_gap_done) w_state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Pop strobe to the owner in the same cycle its word is accepted
   always_comb begin
      req_ready = '0;
      if (w_accept) req_ready = r_grant;
   end

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Grant, pointer, output word and gap counter
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ptr        <= IW'(NUM_REQ - 1);
         r_grant      <= '0;
         r_pkt_active <= 1'b0;
         r_en         <= 1'b0;
         r_data       <= '0;
         r_last       <= 1'b0;
         r_gap_cnt    <= '0;
      end else begin
         r_en <= w_accept;
         if (r_state == ST_ARB && w_any) begin
            r_grant      <= w_win_oh;
            r_ptr        <= w_win_idx;
            r_pkt_active <= 1'b1;
         end
         if (w_accept) begin
            r_data <= w_g_data;
            r_last <= w_g_last;
         end
         // counter holds at its terminal value instead of wrapping
         if (r_state != ST_GAP)  r_gap_cnt <= '0;
         else if (!w_gap_done)   r_gap_cnt <= r_gap_cnt + 1'b1;
         if (w_state_nxt == ST_RELEASE) begin
            r_grant      <= '0;
            r_pkt_active <= 1'b0;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int TW = idx_width(LOCK_TIMEOUT + 1);

   logic [TW-1:0] r_to_cnt;
   logic          r_lock_err;

   assign w_to_hit = (r_state == ST_ISSUE) && !w_g_valid &&
                     (int'(r_to_cnt) >= LOCK_TIMEOUT - 1);

   // Count starved ISSUE cycles; sticky error once the lock is broken
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_to_cnt   <= '0;
         r_lock_err <= 1'b0;
      end else begin
         if (r_state != ST_ISSUE || w_accept)
            r_to_cnt <= '0;
         else if (!w_g_valid && int'(r_to_cnt) < LOCK_TIMEOUT)
            r_to_cnt <= r_to_cnt + 1'b1;
         if (w_to_hit) r_lock_err <= 1'b1;
      end
   end

   assign lock_err = r_lock_err;
`else
   assign w_to_hit = 1'b0;
`endif

   assign grant        = r_grant;
   assign pkt_active   = r_pkt_active;
   assign uart_tx_en   = r_en;
   assign uart_tx_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed bench for uart_tx_arbiter with four requesters, a
//               behavioural uart_tx (busy for 10 clocks per word) and
//               packet-queue requesters. Timeout scenario runs only when
//               ARB_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NR  = 4;
   localparam int PB  = 11;
   localparam int GAP = 20;

   logic            clk = 1'b0;
   logic            resetn = 1'b0;
   logic [NR-1:0]   req_valid;
   logic [NR*PB-1:0] req_data;
   logic [NR-1:0]   req_last;
   logic [NR-1:0]   req_ready;
   logic [NR-1:0]   grant;
   logic            uart_tx_en;
   logic [PB-1:0]   uart_tx_data;
   logic            uart_tx_busy;
   logic            pkt_active;
`ifdef ARB_TIMEOUT_EN
   logic            lock_err;
`endif

   int errors = 0;
   int checks = 0;

   // requester packet storage
   logic [PB-1:0] wd  [NR][8];
   bit            lst [NR][8];
   int            len [NR];
   int            base [NR];
   int            pop_cnt [NR];
   bit            hold [NR];
   int            rq_k;

   // uart_tx model state and logs
   bit            busy;
   int            bcnt;
   int            cyc;
   int            en_while_busy;
   logic [PB-1:0] log_data [$];
   logic [NR-1:0] log_grant [$];
   int            log_cyc [$];
   int            fall_cyc [$];

   assign uart_tx_busy = busy;

   uart_tx_arbiter #(
      .NUM_REQ      (NR),
      .PAYLOAD_BITS (PB),
      .GAP_CYCLES   (GAP)
`ifdef ARB_TIMEOUT_EN
      , .LOCK_TIMEOUT (100)
`endif
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .grant        (grant),
      .uart_tx_en   (uart_tx_en),
      .uart_tx_data (uart_tx_data),
      .uart_tx_busy (uart_tx_busy),
      .pkt_active   (pkt_active)
`ifdef ARB_TIMEOUT_EN
      , .lock_err   (lock_err)
`endif
   );

   always #5 clk = ~clk;

   // requesters present the next unpopped word of their loaded packet
   always_comb begin
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      rq_k      = 0;
      for (int r = 0; r < NR; r++) begin
         rq_k = pop_cnt[r] - base[r];
         if (!hold[r] && rq_k >= 0 && rq_k < len[r]) begin
            req_valid[r]          = 1'b1;
            req_data[r*PB +: PB]  = wd[r][rq_k];
            req_last[r]           = lst[r][rq_k];
         end
      end
   end

   always @(posedge clk) begin
      for (int r = 0; r < NR; r++)
         if (req_ready[r]) pop_cnt[r] <= pop_cnt[r] + 1;
   end

   // uart_tx model: busy rises the clock after the strobe, lasts 10 clocks
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (uart_tx_en) begin
         if (busy) en_while_busy <= en_while_busy + 1;
         log_data.push_back(uart_tx_data);
         log_grant.push_back(grant);
         log_cyc.push_back(cyc);
      end
      if (busy) begin
         if (bcnt == 1) begin
            busy <= 1'b0;
            fall_cyc.push_back(cyc);
         end
         bcnt <= bcnt - 1;
      end else if (uart_tx_en) begin
         busy <= 1'b1;
         bcnt <= 10;
      end
   end

   task automatic set_word(input int r, input int i, input logic [PB-1:0] d, input bit l);
      wd[r][i]  = d;
      lst[r][i] = l;
   endtask

   task automatic load(input int r, input int n);
      base[r] = pop_cnt[r];
      len[r]  = n;
   endtask

   task automatic wait_done(input int target, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (log_data.size() >= target && !pkt_active && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
      checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", uart_tx_en); end
      checks++; if (uart_tx_data !== 11'h000) begin errors++; $display("FAIL reset_data: got %h want 000", uart_tx_data); end
      checks++; if (pkt_active !== 1'b0) begin errors++; $display("FAIL reset_pkt_active: got %b want 0", pkt_active); end
      resetn = 1'b1;
   endtask

   task automatic test_single_packet;
      int b;
      bit ok;
      logic [PB-1:0] exp_d [3];
      exp_d = '{11'h0F0, 11'h123, 11'h7FF};
      @(negedge clk);
      b = log_data.size();
      set_word(0, 0, exp_d[0], 1'b0);
      set_word(0, 1, exp_d[1], 1'b0);
      set_word(0, 2, exp_d[2], 1'b1);
      load(0, 3);
      @(negedge clk);
      checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL lat_arb_en: got %b want 0", uart_tx_en); end
      @(negedge clk);
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL lat_issue_ready: got %b want 0001", req_ready); end
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL lat_issue_grant: got %b want 0001", grant); end
      checks++; if (pkt_active !== 1'b1) begin errors++; $display("FAIL lat_pkt_active: got %b want 1", pkt_active); end
      @(negedge clk);
      checks++; if (uart_tx_en !== 1'b1) begin errors++; $display("FAIL lat_strobe: got %b want 1", uart_tx_en); end
      checks++; if (uart_tx_data !== 11'h0F0) begin errors++; $display("FAIL lat_data: got %h want 0f0", uart_tx_data); end
      wait_done(b + 3, 300, ok);
      checks++; if (!ok || log_data.size() != b + 3) begin errors++; $display("FAIL single_count: got %0d words want 3", log_data.size() - b); end
      for (int i = 0; i < 3; i++) begin
         if (log_data.size() > b + i) begin
            checks++; if (log_data[b+i] !== exp_d[i]) begin errors++; $display("FAIL single_data[%0d]: got %h want %h", i, log_data[b+i], exp_d[i]); end
            checks++; if (log_grant[b+i] !== 4'b0001) begin errors++; $display("FAIL single_grant[%0d]: got %b want 0001", i, log_grant[b+i]); end
         end
      end
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_release: got %b want 0000", grant); end
   endtask

   task automatic test_contention;
      int b, fb;
      bit ok;
      logic [PB-1:0] exp_d [6];
      logic [NR-1:0] exp_g [6];
      exp_d = '{11'h101, 11'h102, 11'h201, 11'h202, 11'h103, 11'h104};
      exp_g = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0001, 4'b0001};
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      b  = log_data.size();
      fb = fall_cyc.size();
      set_word(0, 0, 11'h101, 1'b0);
      set_word(0, 1, 11'h102, 1'b1);
      set_word(0, 2, 11'h103, 1'b0);
      set_word(0, 3, 11'h104, 1'b1);
      set_word(1, 0, 11'h201, 1'b0);
      set_word(1, 1, 11'h202, 1'b1);
      load(0, 4);
      load(1, 2);
      wait_done(b + 6, 600, ok);
      checks++; if (!ok || log_data.size() != b + 6) begin errors++; $display("FAIL cont_count: got %0d words want 6", log_data.size() - b); end
      for (int i = 0; i < 6; i++) begin
         if (log_data.size() > b + i) begin
            checks++; if (log_data[b+i] !== exp_d[i]) begin errors++; $display("FAIL cont_data[%0d]: got %h want %h", i, log_data[b+i], exp_d[i]); end
            checks++; if (log_grant[b+i] !== exp_g[i]) begin errors++; $display("FAIL cont_grant[%0d]: got %b want %b", i, log_grant[b+i], exp_g[i]); end
         end
      end
      if (log_cyc.size() > b + 1 && fall_cyc.size() > fb) begin
         checks++; if (log_cyc[b+1] - fall_cyc[fb] >= GAP) begin errors++; $display("FAIL cont_word_spacing: got %0d clocks want < %0d", log_cyc[b+1] - fall_cyc[fb], GAP); end
      end
   endtask

   task automatic test_gap;
      int b, fb;
      bit ok;
      @(negedge clk);
      b  = log_data.size();
      fb = fall_cyc.size();
      set_word(3, 0, 11'h3C1, 1'b1);
      set_word(3, 1, 11'h3C2, 1'b1);
      load(3, 2);
      wait_done(b + 2, 300, ok);
      checks++; if (!ok || log_data.size() != b + 2) begin errors++; $display("FAIL gap_count: got %0d words want 2", log_data.size() - b); end
      if (log_data.size() >= b + 2 && fall_cyc.size() > fb) begin
         checks++; if (log_data[b+1] !== 11'h3C2) begin errors++; $display("FAIL gap_data: got %h want 3c2", log_data[b+1]); end
         checks++; if (log_grant[b+1] !== 4'b1000) begin errors++; $display("FAIL gap_grant: got %b want 1000", log_grant[b+1]); end
         checks++; if (log_cyc[b+1] - fall_cyc[fb] < GAP) begin errors++; $display("FAIL gap_idle: got %0d clocks want >= %0d", log_cyc[b+1] - fall_cyc[fb], GAP); end
      end
   endtask

   task automatic test_stall;
      int b, n0, p0, bad_g, bad_en, bad_r;
      bit ok;
      logic [PB-1:0] exp_d [4];
      logic [NR-1:0] exp_g [4];
      exp_d = '{11'h211, 11'h222, 11'h233, 11'h0EE};
      exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
      @(negedge clk);
      b = log_data.size();
      set_word(1, 0, 11'h211, 1'b0);
      set_word(1, 1, 11'h222, 1'b0);
      set_word(1, 2, 11'h233, 1'b1);
      load(1, 3);
      p0 = pop_cnt[1];
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pop_cnt[1] != p0) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL stall_first_pop: got no pop want one within 40 clocks"); end
      hold[1] = 1'b1;
      set_word(0, 0, 11'h0EE, 1'b1);
      load(0, 1);
      @(negedge clk);
      n0 = log_data.size();
      bad_g = 0; bad_en = 0; bad_r = 0;
      repeat (50) begin
         @(negedge clk);
         if (grant !== 4'b0010) bad_g++;
         if (uart_tx_en !== 1'b0) bad_en++;
         if (req_ready !== 4'b0000) bad_r++;
      end
      checks++; if (bad_g != 0) begin errors++; $display("FAIL stall_grant_held: got %0d bad clocks want 0", bad_g); end
      checks++; if (bad_en != 0 || log_data.size() != n0) begin errors++; $display("FAIL stall_no_strobe: got %0d strobes want 0", bad_en); end
      checks++; if (bad_r != 0) begin errors++; $display("FAIL stall_no_ready: got %0d bad clocks want 0", bad_r); end
      hold[1] = 1'b0;
      wait_done(b + 4, 400, ok);
      checks++; if (!ok || log_data.size() != b + 4) begin errors++; $display("FAIL stall_count: got %0d words want 4", log_data.size() - b); end
      for (int i = 0; i < 4; i++) begin
         if (log_data.size() > b + i) begin
            checks++; if (log_data[b+i] !== exp_d[i]) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, log_data[b+i], exp_d[i]); end
            checks++; if (log_grant[b+i] !== exp_g[i]) begin errors++; $display("FAIL stall_grant[%0d]: got %b want %b", i, log_grant[b+i], exp_g[i]); end
         end
      end
   endtask

   task automatic test_reset_midword;
      int b, fb;
      bit ok;
      @(negedge clk);
      b  = log_data.size();
      fb = fall_cyc.size();
      set_word(0, 0, 11'h2AA, 1'b0);
      set_word(0, 1, 11'h155, 1'b1);
      load(0, 2);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL rst_word_start: got busy=0 want busy within 40 clocks"); end
      repeat (2) @(negedge clk);
      #1 resetn = 1'b0;
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_async_grant: got %b want 0000", grant); end
      checks++; if (uart_tx_data !== 11'h000) begin errors++; $display("FAIL rst_async_data: got %h want 000", uart_tx_data); end
      checks++; if (pkt_active !== 1'b0) begin errors++; $display("FAIL rst_async_pkt_active: got %b want 0", pkt_active); end
      checks++; if (uart_tx_en !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL rst_async_strobes: got en=%b ready=%b want 0/0000", uart_tx_en, req_ready); end
      load(0, 0);
      @(negedge clk);
      resetn = 1'b1;
      set_word(2, 0, 11'h0AB, 1'b1);
      load(2, 1);
      wait_done(b + 2, 300, ok);
      checks++; if (!ok || log_data.size() != b + 2) begin errors++; $display("FAIL rst_after_count: got %0d words want 2", log_data.size() - b); end
      if (log_data.size() >= b + 2 && fall_cyc.size() > fb) begin
         checks++; if (log_data[b+1] !== 11'h0AB) begin errors++; $display("FAIL rst_after_data: got %h want 0ab", log_data[b+1]); end
         checks++; if (log_grant[b+1] !== 4'b0100) begin errors++; $display("FAIL rst_after_grant: got %b want 0100", log_grant[b+1]); end
         checks++; if (log_cyc[b+1] <= fall_cyc[fb]) begin errors++; $display("FAIL rst_after_wait_busy: got strobe at %0d want after %0d", log_cyc[b+1], fall_cyc[fb]); end
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout;
      int b, p0, n;
      bit ok;
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      checks++; if (lock_err !== 1'b0) begin errors++; $display("FAIL to_reset_err: got %b want 0", lock_err); end
      b = log_data.size();
      set_word(0, 0, 11'h011, 1'b0);
      set_word(0, 1, 11'h022, 1'b0);
      set_word(0, 2, 11'h033, 1'b1);
      load(0, 3);
      p0 = pop_cnt[0];
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pop_cnt[0] != p0) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL to_first_pop: got no pop want one within 40 clocks"); end
      hold[0] = 1'b1;
      set_word(1, 0, 11'h1F1, 1'b1);
      load(1, 1);
      n = 0;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         n++;
         if (grant === 4'b0010) begin ok = 1'b1; break; end
      end
      checks++; if (!ok || n < 100 || n > 140) begin errors++; $display("FAIL to_release_time: got %0d clocks want 100..140", n); end
      checks++; if (lock_err !== 1'b1) begin errors++; $display("FAIL to_lock_err: got %b want 1", lock_err); end
      load(0, 0);
      hold[0] = 1'b0;
      wait_done(b + 2, 300, ok);
      checks++; if (!ok || log_data.size() != b + 2) begin errors++; $display("FAIL to_count: got %0d words want 2", log_data.size() - b); end
      if (log_data.size() >= b + 2) begin
         checks++; if (log_data[b+1] !== 11'h1F1) begin errors++; $display("FAIL to_next_data: got %h want 1f1", log_data[b+1]); end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_packet();
      test_contention();
      test_gap();
      test_stall();
      test_reset_midword();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (en_while_busy != 0) begin
         errors++;
         $display("FAIL strobe_while_busy: got %0d strobes want 0", en_while_busy);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
